// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtractor.
// The optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk build still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit borrow-ripple subtractor: d = a - b - bi, bo = borrow out.
module sub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bi,
   output logic [CHUNK-1:0] d,
   output logic             bo
);

   logic brw;

   always_comb begin
      d   = '0;
      brw = bi;
      for (int i = 0; i < CHUNK; i++) begin
         d[i] = a[i] ^ b[i] ^ brw;
         brw  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
      end
      bo = brw;
   end

endmodule

// File: rtl/serial_subtractor_32.sv
// Multi-cycle unsigned subtractor, one CHUNK-bit slice per cycle, LSB chunk first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor_32
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("serial_subtractor_32: CHUNK must divide WIDTH exactly");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready is high only in IDLE outside reset; out_valid is high only in DONE.

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              brw_q, brw_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic              bout_q, bout_d;
   logic              ovf_q, ovf_d;

   logic [CHUNK-1:0]  a_slice, b_slice, slice_d;
   logic              slice_bo;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_q == CW'(i)) begin
            a_slice = a_q[i*CHUNK +: CHUNK];
            b_slice = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
      .a  (a_slice),
      .b  (b_slice),
      .bi (brw_q),
      .d  (slice_d),
      .bo (slice_bo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in1;
               b_d     = in2;
               brw_d   = bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (cnt_q == CW'(i)) diff_d[i*CHUNK +: CHUNK] = slice_d;
            end
            brw_d = slice_bo;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               bout_d  = slice_bo;
               // The final slice carries the result msb.
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_d[CHUNK-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule
